// File: rtl/rr_priority_arbiter_pkg.sv
// Shared types for the round-robin / fixed-priority arbiter.
package rr_priority_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_priority_arbiter_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
interface rr_priority_arbiter_if #(
    parameter int NUM_REQ = 16
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] req_i;
    logic               gnt_ready_i;
    logic               gnt_valid_o;
    logic [IDX_W-1:0]   gnt_idx_o;
    logic [NUM_REQ-1:0] gnt_onehot_o;

    modport master (
        output req_i,
        output gnt_ready_i,
        input  gnt_valid_o,
        input  gnt_idx_o,
        input  gnt_onehot_o
    );

    modport slave (
        input  req_i,
        input  gnt_ready_i,
        output gnt_valid_o,
        output gnt_idx_o,
        output gnt_onehot_o
    );

endinterface

// File: rtl/priority_encoder.sv
// Combinational lowest-index-first priority encoder.
module priority_encoder #(
    parameter  int NUM_WIRE = 16,
    localparam int IDX_W    = $clog2(NUM_WIRE)
) (
    input  logic [NUM_WIRE-1:0] wire_i,
    output logic [IDX_W-1:0]    index_o,
    output logic                index_valid_o
);

    // Scan downward so the lowest set bit is the last one written.
    always_comb begin
        index_o       = '0;
        index_valid_o = 1'b0;
        for (int i = NUM_WIRE - 1; i >= 0; i--) begin
            if (wire_i[i]) begin
                index_o       = IDX_W'(i);
                index_valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_priority_arbiter.sv
// Registered arbiter with valid/ready grant; round-robin or fixed priority.
module rr_priority_arbiter
    import rr_priority_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 16,
    parameter int RR_MODE = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    rr_priority_arbiter_if.slave bus
);

    localparam int               IDX_W    = $clog2(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

    arb_state_t         state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [IDX_W-1:0]   ptr;
    logic [NUM_REQ-1:0] above_mask;
    logic [NUM_REQ-1:0] req_masked;
    logic [IDX_W-1:0]   masked_idx, raw_idx, win_idx;
    logic               masked_vld, raw_vld;
    logic               handshake;

    assign handshake = (state_q == ARB_GRANT) && bus.gnt_ready_i;

    // Re-arbitration on a handshake uses the index just accepted as the pointer.
    assign ptr    = (RR_MODE != 0 && handshake) ? idx_q : last_q;
    assign last_d = (RR_MODE != 0 && handshake) ? idx_q : last_q;

    always_comb begin
        above_mask = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            above_mask[i] = (i > int'(ptr));
        end
    end

    assign req_masked = (RR_MODE != 0) ? (bus.req_i & above_mask) : '0;

    priority_encoder #(.NUM_WIRE(NUM_REQ)) u_enc_masked (
        .wire_i        (req_masked),
        .index_o       (masked_idx),
        .index_valid_o (masked_vld)
    );

    priority_encoder #(.NUM_WIRE(NUM_REQ)) u_enc_raw (
        .wire_i        (bus.req_i),
        .index_o       (raw_idx),
        .index_valid_o (raw_vld)
    );

    // Nothing above the pointer means wrap around to the lowest requester.
    assign win_idx = masked_vld ? masked_idx : raw_idx;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ARB_IDLE;
            idx_q   <= '0;
            last_q  <= LAST_RST;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (raw_vld) begin
                    state_d = ARB_GRANT;
                    idx_d   = win_idx;
                end
            end
            ARB_GRANT: begin
                if (bus.gnt_ready_i) begin
                    if (raw_vld) begin
                        idx_d = win_idx;
                    end else begin
                        state_d = ARB_IDLE;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        bus.gnt_valid_o  = (state_q == ARB_GRANT);
        bus.gnt_idx_o    = idx_q;
        bus.gnt_onehot_o = '0;
        if (state_q == ARB_GRANT) begin
            bus.gnt_onehot_o[idx_q] = 1'b1;
        end
    end

endmodule

// File: tb/tb_rr_priority_arbiter.sv
// Directed + random bench; round-robin and fixed-priority instances share stimulus.
module tb_rr_priority_arbiter;

    localparam int N = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] req = '0;
    logic         rdy = 1'b0;

    always #5 clk = ~clk;

    rr_priority_arbiter_if #(.NUM_REQ(N)) bus_rr ();
    rr_priority_arbiter_if #(.NUM_REQ(N)) bus_fx ();

    assign bus_rr.req_i       = req;
    assign bus_rr.gnt_ready_i = rdy;
    assign bus_fx.req_i       = req;
    assign bus_fx.gnt_ready_i = rdy;

    rr_priority_arbiter #(.NUM_REQ(N), .RR_MODE(1)) u_rr (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_rr)
    );

    rr_priority_arbiter #(.NUM_REQ(N), .RR_MODE(0)) u_fx (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_fx)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: index 1 = round-robin, index 0 = fixed priority.
    bit m_vld [2];
    int m_idx [2];
    int m_last[2];

    function automatic int pick(input logic [N-1:0] r, input int last, input bit rr);
        if (!rr) begin
            for (int i = 0; i < N; i++) if (r[i]) return i;
            return 0;
        end
        for (int k = 1; k <= N; k++) begin
            int j;
            j = (last + k) % N;
            if (r[j]) return j;
        end
        return 0;
    endfunction

    task automatic model_edge(input logic [N-1:0] r, input logic rd, input logic rs);
        for (int m = 0; m < 2; m++) begin
            if (rs) begin
                m_vld[m]  = 1'b0;
                m_idx[m]  = 0;
                m_last[m] = N - 1;
            end else if (!m_vld[m]) begin
                if (r != '0) begin
                    m_vld[m] = 1'b1;
                    m_idx[m] = pick(r, m_last[m], m[0]);
                end
            end else if (rd) begin
                if (m == 1) m_last[m] = m_idx[m];
                if (r != '0) m_idx[m] = pick(r, m_last[m], m[0]);
                else         m_vld[m] = 1'b0;
            end
        end
    endtask

    task automatic check_outputs();
        logic [31:0] oh;
        oh = m_vld[1] ? (32'd1 << m_idx[1]) : 32'd0;
        chk("rr_valid", 32'(bus_rr.gnt_valid_o), 32'(m_vld[1]));
        if (m_vld[1]) chk("rr_idx", 32'(bus_rr.gnt_idx_o), 32'(m_idx[1]));
        chk("rr_onehot", 32'(bus_rr.gnt_onehot_o), oh);
        oh = m_vld[0] ? (32'd1 << m_idx[0]) : 32'd0;
        chk("fx_valid", 32'(bus_fx.gnt_valid_o), 32'(m_vld[0]));
        if (m_vld[0]) chk("fx_idx", 32'(bus_fx.gnt_idx_o), 32'(m_idx[0]));
        chk("fx_onehot", 32'(bus_fx.gnt_onehot_o), oh);
    endtask

    // Starvation tracking on the round-robin instance: transfers to others while a request persists.
    bit track = 1'b0;
    int wcnt[N];
    int wmax = 0;

    task automatic step(input logic [N-1:0] r, input logic rd, input logic rs);
        req = r;
        rdy = rd;
        rst = rs;
        #1;
        if (track) begin
            for (int i = 0; i < N; i++) begin
                if (rs || !req[i]) wcnt[i] = 0;
                else if (bus_rr.gnt_valid_o && rdy) begin
                    if (int'(bus_rr.gnt_idx_o) == i) wcnt[i] = 0;
                    else                             wcnt[i]++;
                end
                if (wcnt[i] > wmax) wmax = wcnt[i];
            end
        end
        @(posedge clk);
        model_edge(r, rd, rs);
        #1;
        check_outputs();
    endtask

    initial begin
        // Reset with every requester active.
        step('1, 1'b0, 1'b1);
        chk("rst_valid", 32'(bus_rr.gnt_valid_o), 32'd0);
        chk("rst_onehot", 32'(bus_rr.gnt_onehot_o), 32'd0);

        // Full rotation, no bubbles.
        step(16'hFFFF, 1'b1, 1'b0);
        chk("first_after_rst", 32'(bus_rr.gnt_idx_o), 32'd0);
        for (int k = 1; k <= N; k++) begin
            step(16'hFFFF, 1'b1, 1'b0);
            chk("rot_valid", 32'(bus_rr.gnt_valid_o), 32'd1);
            chk("rot_idx", 32'(bus_rr.gnt_idx_o), 32'(k % N));
        end

        // Skip and wrap.
        step(16'h8005, 1'b0, 1'b1);
        begin
            int exp_rr[4];
            exp_rr = '{0, 2, 15, 0};
            for (int k = 0; k < 4; k++) begin
                step(16'h8005, 1'b1, 1'b0);
                chk("wrap_rr", 32'(bus_rr.gnt_idx_o), 32'(exp_rr[k]));
                chk("wrap_fx", 32'(bus_fx.gnt_idx_o), 32'd0);
            end
        end

        // Stall holds grant 3 while requests change.
        step(16'h0000, 1'b0, 1'b1);
        step(16'h0008, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            step(16'h0001, 1'b0, 1'b0);
            chk("stall_idx", 32'(bus_rr.gnt_idx_o), 32'd3);
        end
        step(16'h0001, 1'b1, 1'b0);
        chk("stall_release", 32'(bus_rr.gnt_idx_o), 32'd0);

        // Drain to idle.
        step(16'h0000, 1'b0, 1'b1);
        step(16'h0080, 1'b0, 1'b0);
        chk("drain_idx", 32'(bus_rr.gnt_idx_o), 32'd7);
        step(16'h0000, 1'b1, 1'b0);
        chk("drain_valid", 32'(bus_rr.gnt_valid_o), 32'd0);
        step(16'h0000, 1'b1, 1'b0);
        chk("idle_ready", 32'(bus_rr.gnt_valid_o), 32'd0);

        // Random soak with slowly changing requests.
        begin
            logic [N-1:0] r;
            logic         rs;
            r     = '0;
            track = 1'b1;
            for (int i = 0; i < N; i++) wcnt[i] = 0;
            for (int c = 0; c < 1000; c++) begin
                for (int i = 0; i < N; i++)
                    if ($urandom_range(7) == 0) r[i] = ~r[i];
                rs = ($urandom_range(199) == 0);
                step(r, ($urandom_range(3) != 0), rs);
            end
            track = 1'b0;
            chk("starvation_bound", 32'(wmax <= N - 1), 32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_priority_arbiter.md
# rr_priority_arbiter

Registered, parameterised arbiter built on the combinational `priority_encoder`. It selects one of `NUM_REQ` requesters and presents the winner with a valid/ready handshake. It supports fixed (lowest-index-first) and round-robin priority modes. It sits in front of shared resources such as a writeback port or an issue slot, where several sources compete each cycle and the consumer may stall.

## Interface
- `NUM_REQ`, default 16: number of requesters; legal range ≥ 2.
- `RR_MODE`, default 1: 1 = round-robin priority; 0 = fixed priority, index 0 highest.
- `IDX_W`, derived, `$clog2(NUM_REQ)`: not overridable.

Clock and reset: one clock; reset is synchronous and active-high.

- `clk_i`  input  1  clock; all state updates on the rising edge.
- `rst_i`  input  1  synchronous, active-high reset.
- `req_i`  input  NUM_REQ  request vector; bit i set means requester i wants a grant.
- `gnt_ready_i`  input  1  consumer accepts the current grant.
- `gnt_valid_o`  output  1  a grant is presented.
- `gnt_idx_o`  output  IDX_W  binary index of the granted requester.
- `gnt_onehot_o`  output  NUM_REQ  one-hot form of `gnt_idx_o`; all zero when `gnt_valid_o` = 0.

## Operation
- **State machine:** two states, IDLE and GRANT. Reset enters IDLE.
- **IDLE:**
  - If `|req_i` = 1, register the winner, set `gnt_valid_o`, and go to GRANT.
  - Otherwise stay in IDLE.
- **GRANT, no handshake** (`gnt_ready_i` = 0): `gnt_idx_o` and `gnt_onehot_o` hold exactly. Changes on `req_i`, including the winner deasserting, are ignored. There is no preemption.
- **GRANT, handshake** (`gnt_ready_i` = 1):
  - Update the pointer to `last_q` ← `gnt_idx_o` (round-robin mode only).
  - Re-arbitrate in the same cycle on the current `req_i` using the updated pointer.
  - If any request is present, stay in GRANT with the new winner. Otherwise go to IDLE and deassert `gnt_valid_o`.
- **Winner selection, RR_MODE = 1:**
  - Masked vector: `req_i` with bits 0..`last` cleared, so only indices strictly above `last` remain.
  - If the masked vector is non-zero, the winner is its lowest set bit. Otherwise the winner is the lowest set bit of the unmasked `req_i`. This gives wrap-around.
- **Winner selection, RR_MODE = 0:** the winner is the lowest set bit of `req_i`. `last_q` is unused and held at reset value.
- **Re-arbitration input:** when a handshake coincides with arbitration, the pointer used is the value after the update, i.e. the index just accepted. A requester that holds `req_i` high is served again only if no other requester is pending (round-robin mode).
- **Reset values:**
  - `gnt_valid_o` = 0, `gnt_idx_o` = 0, `gnt_onehot_o` = 0.
  - `last_q` = `NUM_REQ`−1, so index 0 has top priority after reset.
- **Reset during GRANT:** the grant is dropped on that edge without a handshake, and the pointer returns to `NUM_REQ`−1.

## Timing
- All outputs are registered. There is no combinational path from `req_i` or `gnt_ready_i` to any output.
- Latency: `req_i` sampled at edge N gives `gnt_valid_o` = 1 after edge N.
- Throughput: one grant per cycle while `gnt_ready_i` = 1 and requests persist. There are no bubbles between back-to-back grants.
- **Handshake rule:** a transfer occurs on the edge where `gnt_valid_o` & `gnt_ready_i` = 1.
- **`gnt_ready_i` while idle:** `gnt_ready_i` with `gnt_valid_o` = 0 has no effect.
- **Reset priority:** `rst_i` wins over every other event on the same edge.

## Structure
- No shared-package additions. `IDX_W` and the masks are derived locally from `NUM_REQ`.
- Reuse two instances of the existing `priority_encoder` sub-module with `NUM_WIRE` = `NUM_REQ`:
  - one on the masked vector;
  - one on the unmasked vector.
- The winner is chosen by the masked instance's `index_valid_o`.
- `gnt_onehot_o` is decoded from the registered index and gated by `gnt_valid_o`.

## Test plan
- **Reset:** assert `rst_i` with `req_i` = 16'hFFFF → next cycle `gnt_valid_o` = 0, `gnt_onehot_o` = 0. First grant after release has `gnt_idx_o` = 0.
- **Round-robin rotation:** `req_i` = 16'hFFFF held, `gnt_ready_i` = 1 → indices 0, 1, …, 15, 0 on consecutive cycles with no bubble.
- **Skip and wrap:** `req_i` = 16'h8005, `RR_MODE` = 1 → sequence 0, 2, 15, 0. Same stimulus with `RR_MODE` = 0 → 0, 0, 0.
- **Stall stability:** grant index 3 with `gnt_ready_i` = 0 for 5 cycles while `req_i` changes to 16'h0001 → `gnt_idx_o` = 3 held for all 5 cycles. Raising ready gives next grant 0.
- **Drain to idle:** single request on bit 7 accepted, then `req_i` = 0 → `gnt_valid_o` = 0 on the following cycle and the FSM is in IDLE.
- **Random soak:** 1000 cycles of random `req_i` and `gnt_ready_i` → reference-model match on every handshake; no starvation beyond `NUM_REQ`−1 intervening grants for a persistent requester.
